memory_access_stage: RTL and testbench

//  Y86-64 memory stage with M/W pipeline register. Takes execute results,

---
 rtl/y86_pkg.sv | 51 +++++
 rtl/data_memory.sv | 31 +++
 rtl/memory_access_stage.sv | 139 +++++++++++++
 tb/tb_memory_access_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the memory-access decode used by the memory stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] RSP   = 4'd4;
  localparam logic [3:0] RNONE = 4'd15;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_req_t;

  // Pops and returns read through the old stack pointer carried in val_a.
  function automatic mem_req_t decode_access(input logic [3:0]  icode,
                                             input logic [63:0] val_e,
                                             input logic [63:0] val_a,
                                             input logic [63:0] val_p);
    mem_req_t req;
    req = '0;
    case (icode)
      I_RMMOVQ: begin req.wr = 1'b1; req.addr = val_e; req.wdata = val_a; end
      I_MRMOVQ: begin req.rd = 1'b1; req.addr = val_e; end
      I_CALL:   begin req.wr = 1'b1; req.addr = val_e; req.wdata = val_p; end
      I_RET:    begin req.rd = 1'b1; req.addr = val_a; end
      I_PUSHQ:  begin req.wr = 1'b1; req.addr = val_e; req.wdata = val_a; end
      I_POPQ:   begin req.rd = 1'b1; req.addr = val_a; end
      default:  req = '0;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-array data memory: 8-byte little-endian combinational read, synchronous write.
module data_memory #(
  parameter int unsigned MEM_BYTES = 1024,
  localparam int unsigned AW = $clog2(MEM_BYTES)
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];

  // Byte indices wrap within AW bits; out-of-range accesses are masked upstream.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Y86-64 memory stage: data-memory access, address check and the M/W pipeline register.
module memory_access_stage
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        e_valid,
  input  logic [1:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [3:0]  e_ra,
  input  logic [3:0]  e_rb,
  input  logic [63:0] e_val_e,
  input  logic [63:0] e_val_a,
  input  logic [63:0] e_val_p,
  input  logic        stall,
  input  logic        bubble,
  output logic [1:0]  m_stat,
  output logic        w_valid,
  output logic [1:0]  w_stat,
  output logic [3:0]  w_icode,
  output logic        w_cnd,
  output logic [3:0]  w_ra,
  output logic [3:0]  w_rb,
  output logic [63:0] w_val_e,
  output logic [63:0] w_val_m,
  output logic        halted
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam logic [63:0] MaxAddr = 64'(MEM_BYTES - 8);

  mem_req_t    req;
  logic        adr_err;
  logic        mem_we;
  logic [63:0] rdata;
  logic [63:0] val_m;

  logic        w_valid_q, w_valid_d;
  logic [1:0]  w_stat_q,  w_stat_d;
  logic [3:0]  w_icode_q, w_icode_d;
  logic        w_cnd_q,   w_cnd_d;
  logic [3:0]  w_ra_q,    w_ra_d;
  logic [3:0]  w_rb_q,    w_rb_d;
  logic [63:0] w_val_e_q, w_val_e_d;
  logic [63:0] w_val_m_q, w_val_m_d;
  logic        halted_q,  halted_d;

  always_comb begin
    req     = decode_access(e_icode, e_val_e, e_val_a, e_val_p);
    adr_err = (req.rd || req.wr) && (req.addr > MaxAddr);
    m_stat  = adr_err ? S_ADR : e_stat;
    val_m   = (req.rd && !adr_err) ? rdata : 64'd0;
    // reset_n gating drops a store that coincides with reset.
    mem_we  = req.wr && e_valid && !stall && !halted_q && reset_n &&
              (m_stat == S_AOK) && (e_stat == S_AOK);
  end

  data_memory #(
    .MEM_BYTES (MEM_BYTES)
  ) u_mem (
    .clock (clock),
    .addr  (req.addr[AW-1:0]),
    .we    (mem_we),
    .wdata (req.wdata),
    .rdata (rdata)
  );

  always_comb begin
    w_valid_d = w_valid_q;
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_cnd_d   = w_cnd_q;
    w_ra_d    = w_ra_q;
    w_rb_d    = w_rb_q;
    w_val_e_d = w_val_e_q;
    w_val_m_d = w_val_m_q;
    halted_d  = halted_q;
    if (!stall) begin
      if (bubble || !e_valid) begin
        w_valid_d = 1'b0;
        w_stat_d  = S_AOK;
        w_icode_d = I_NOP;
        w_cnd_d   = 1'b0;
        w_ra_d    = 4'd0;
        w_rb_d    = 4'd0;
        w_val_e_d = 64'd0;
        w_val_m_d = 64'd0;
      end else begin
        w_valid_d = 1'b1;
        w_stat_d  = m_stat;
        w_icode_d = e_icode;
        w_cnd_d   = e_cnd;
        w_ra_d    = e_ra;
        w_rb_d    = e_rb;
        w_val_e_d = e_val_e;
        w_val_m_d = val_m;
        if (m_stat != S_AOK) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      w_valid_q <= 1'b0;
      w_stat_q  <= S_AOK;
      w_icode_q <= I_NOP;
      w_cnd_q   <= 1'b0;
      w_ra_q    <= 4'd0;
      w_rb_q    <= 4'd0;
      w_val_e_q <= 64'd0;
      w_val_m_q <= 64'd0;
      halted_q  <= 1'b0;
    end else begin
      w_valid_q <= w_valid_d;
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_cnd_q   <= w_cnd_d;
      w_ra_q    <= w_ra_d;
      w_rb_q    <= w_rb_d;
      w_val_e_q <= w_val_e_d;
      w_val_m_q <= w_val_m_d;
      halted_q  <= halted_d;
    end
  end

  assign w_valid = w_valid_q;
  assign w_stat  = w_stat_q;
  assign w_icode = w_icode_q;
  assign w_cnd   = w_cnd_q;
  assign w_ra    = w_ra_q;
  assign w_rb    = w_rb_q;
  assign w_val_e = w_val_e_q;
  assign w_val_m = w_val_m_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with hand-computed expectations.
module tb_memory_access_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        e_valid;
  logic [1:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [3:0]  e_ra, e_rb;
  logic [63:0] e_val_e, e_val_a, e_val_p;
  logic        stall, bubble;
  logic [1:0]  m_stat;
  logic        w_valid;
  logic [1:0]  w_stat;
  logic [3:0]  w_icode;
  logic        w_cnd;
  logic [3:0]  w_ra, w_rb;
  logic [63:0] w_val_e, w_val_m;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  memory_access_stage #(
    .MEM_BYTES (1024)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .e_valid (e_valid),
    .e_stat  (e_stat),
    .e_icode (e_icode),
    .e_cnd   (e_cnd),
    .e_ra    (e_ra),
    .e_rb    (e_rb),
    .e_val_e (e_val_e),
    .e_val_a (e_val_a),
    .e_val_p (e_val_p),
    .stall   (stall),
    .bubble  (bubble),
    .m_stat  (m_stat),
    .w_valid (w_valid),
    .w_stat  (w_stat),
    .w_icode (w_icode),
    .w_cnd   (w_cnd),
    .w_ra    (w_ra),
    .w_rb    (w_rb),
    .w_val_e (w_val_e),
    .w_val_m (w_val_m),
    .halted  (halted)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [63:0] ve, input logic [63:0] va,
                       input logic [63:0] vp);
    e_valid = 1'b1;
    e_stat  = 2'd0;
    e_icode = icode;
    e_cnd   = 1'b1;
    e_ra    = 4'd3;
    e_rb    = 4'd4;
    e_val_e = ve;
    e_val_a = va;
    e_val_p = vp;
  endtask

  task automatic idle();
    e_valid = 1'b0;
    e_stat  = 2'd0;
    e_icode = 4'd1;
    e_cnd   = 1'b0;
    e_ra    = 4'd0;
    e_rb    = 4'd0;
    e_val_e = '0;
    e_val_a = '0;
    e_val_p = '0;
  endtask

  task automatic test_reset();
    idle();
    stall = 1'b0;
    bubble = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_vec++; if (w_icode !== 4'd1) begin n_err++; $display("FAIL reset_icode got %h want 1", w_icode); end
    n_vec++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", w_valid); end
    n_vec++; if (w_stat !== 2'd0) begin n_err++; $display("FAIL reset_stat got %h want 0", w_stat); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
    n_vec++; if (w_val_m !== 64'd0 || w_val_e !== 64'd0) begin
      n_err++; $display("FAIL reset_data got %h/%h want 0/0", w_val_e, w_val_m); end
  endtask

  task automatic preload();
    drive(4'd4, 64'h10, 64'hA5A5_A5A5_A5A5_A5A5, 64'd0);
    tick();
    drive(4'd4, 64'h80, 64'h0102_0304_0506_0708, 64'd0);
    tick();
    drive(4'd4, 64'h100, 64'hCAFE_F00D_DEAD_BEEF, 64'd0);
    tick();
    idle();
    tick();
  endtask

  task automatic test_store_load();
    drive(4'd4, 64'h40, 64'h1122_3344_5566_7788, 64'd0);
    tick();
    n_vec++; if (w_icode !== 4'd4 || w_val_e !== 64'h40 || w_val_m !== 64'd0) begin
      n_err++; $display("FAIL store_wb got %h/%h/%h want 4/40/0", w_icode, w_val_e, w_val_m); end
    drive(4'd5, 64'h40, 64'd0, 64'd0);
    #1;
    n_vec++; if (m_stat !== 2'd0) begin n_err++; $display("FAIL load_mstat got %h want 0", m_stat); end
    tick();
    n_vec++; if (w_val_m !== 64'h1122_3344_5566_7788) begin
      n_err++; $display("FAIL load_valm got %h want 1122334455667788", w_val_m); end
    n_vec++; if (w_valid !== 1'b1 || w_icode !== 4'd5 || w_ra !== 4'd3 || w_rb !== 4'd4 || w_cnd !== 1'b1) begin
      n_err++; $display("FAIL load_fields got %b/%h/%h/%h/%b want 1/5/3/4/1", w_valid, w_icode, w_ra, w_rb, w_cnd); end
    n_vec++; if (dut.u_mem.mem[12'h40] !== 8'h88 || dut.u_mem.mem[12'h47] !== 8'h11) begin
      n_err++; $display("FAIL byte_order got %h/%h want 88/11", dut.u_mem.mem[12'h40], dut.u_mem.mem[12'h47]); end
  endtask

  task automatic test_call_ret();
    drive(4'd8, 64'h1F8, 64'd0, 64'h123);
    tick();
    drive(4'd9, 64'h200, 64'h1F8, 64'd0);
    tick();
    n_vec++; if (w_val_m !== 64'h123 || w_val_e !== 64'h200) begin
      n_err++; $display("FAIL ret_valm got %h/%h want 123/200", w_val_m, w_val_e); end
    drive(4'd10, 64'h1F0, 64'h0000_0000_DEAD_0055, 64'd0);
    tick();
    drive(4'd11, 64'h1F8, 64'h1F0, 64'd0);
    tick();
    n_vec++; if (w_val_m !== 64'h0000_0000_DEAD_0055) begin
      n_err++; $display("FAIL pop_valm got %h want 00000000dead0055", w_val_m); end
  endtask

  task automatic test_addr_error();
    drive(4'd4, 64'h3F8, 64'h8877_6655_4433_2211, 64'd0);
    tick();
    drive(4'd5, 64'h3F8, 64'd0, 64'd0);
    #1;
    n_vec++; if (m_stat !== 2'd0) begin n_err++; $display("FAIL edge_mstat got %h want 0", m_stat); end
    tick();
    n_vec++; if (w_val_m !== 64'h8877_6655_4433_2211 || halted !== 1'b0) begin
      n_err++; $display("FAIL edge_load got %h/%b want 8877665544332211/0", w_val_m, halted); end
    drive(4'd5, 64'h3F9, 64'd0, 64'd0);
    #1;
    n_vec++; if (m_stat !== 2'd2) begin n_err++; $display("FAIL adr_mstat got %h want 2", m_stat); end
    tick();
    n_vec++; if (w_val_m !== 64'd0 || w_stat !== 2'd2 || halted !== 1'b1) begin
      n_err++; $display("FAIL adr_wb got %h/%h/%b want 0/2/1", w_val_m, w_stat, halted); end
    drive(4'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0);
    #1;
    n_vec++; if (m_stat !== 2'd2) begin n_err++; $display("FAIL nowrap_mstat got %h want 2", m_stat); end
    drive(4'd4, 64'h10, 64'h0000_0000_0000_DEAD, 64'd0);
    tick();
    n_vec++; if (dut.u_mem.mem[12'h10] !== 8'hA5 || w_icode !== 4'd4 || halted !== 1'b1) begin
      n_err++; $display("FAIL halted_store got %h/%h/%b want a5/4/1", dut.u_mem.mem[12'h10], w_icode, halted); end
  endtask

  task automatic test_stall_bubble();
    drive(4'd5, 64'h40, 64'd0, 64'd0);
    tick();
    drive(4'd4, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    stall = 1'b1;
    tick();
    n_vec++; if (w_icode !== 4'd5 || w_val_m !== 64'h1122_3344_5566_7788 || w_val_e !== 64'h40) begin
      n_err++; $display("FAIL stall_hold got %h/%h want 5/1122334455667788", w_icode, w_val_m); end
    n_vec++; if (dut.u_mem.mem[12'h80] !== 8'h08) begin
      n_err++; $display("FAIL stall_nowrite got %h want 08", dut.u_mem.mem[12'h80]); end
    stall = 1'b0;
    bubble = 1'b1;
    drive(4'd5, 64'h40, 64'd0, 64'd0);
    tick();
    n_vec++; if (w_icode !== 4'd1 || w_valid !== 1'b0 || w_val_m !== 64'd0) begin
      n_err++; $display("FAIL bubble got %h/%b/%h want 1/0/0", w_icode, w_valid, w_val_m); end
    bubble = 1'b0;
    tick();
    stall = 1'b1;
    bubble = 1'b1;
    drive(4'd6, 64'h77, 64'd0, 64'd0);
    tick();
    n_vec++; if (w_icode !== 4'd5 || w_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_bubble got %h/%b want 5/1", w_icode, w_valid); end
    stall = 1'b0;
    bubble = 1'b0;
    idle();
    tick();
    n_vec++; if (w_icode !== 4'd1 || w_valid !== 1'b0) begin
      n_err++; $display("FAIL invalid_nop got %h/%b want 1/0", w_icode, w_valid); end
  endtask

  task automatic test_halt_status();
    drive(4'd0, 64'd0, 64'd0, 64'd0);
    e_stat = 2'd1;
    tick();
    n_vec++; if (w_stat !== 2'd1 || halted !== 1'b1 || w_icode !== 4'd0) begin
      n_err++; $display("FAIL halt got %h/%b/%h want 1/1/0", w_stat, halted, w_icode); end
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_vec++; if (halted !== 1'b0 || w_icode !== 4'd1 || w_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_reset got %b/%h/%b want 0/1/0", halted, w_icode, w_valid); end
  endtask

  task automatic test_reset_write();
    drive(4'd10, 64'h100, 64'h1111_1111_1111_1111, 64'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    idle();
    n_vec++; if (dut.u_mem.mem[12'h100] !== 8'hEF || dut.u_mem.mem[12'h107] !== 8'hCA) begin
      n_err++; $display("FAIL reset_write got %h/%h want ef/ca", dut.u_mem.mem[12'h100], dut.u_mem.mem[12'h107]); end
  endtask

  initial begin
    idle();
    stall = 1'b0;
    bubble = 1'b0;
    reset_n = 1'b0;
    #1;
    test_reset();
    preload();
    test_store_load();
    test_call_ret();
    test_addr_error();
    test_reset();
    test_stall_bubble();
    test_halt_status();
    test_reset_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
